// File: rtl/or_gate.sv
// ----------------------------------------------------------------------------
// or_gate
//
// Bitwise two-input OR cell with a registered monitoring side-channel.
//
// The primary output y is purely combinational (a | b) and does not depend on
// clk, rst or cnt_clr, so the cell is usable as a plain gate with the clock
// and reset tied off. The registered section offers a pipelined copy of y,
// per-bit rising-edge pulses and a saturating activity counter for status and
// debug logic in the surrounding datapath.
//
// Parameters:
//   WIDTH   - bit width of a, b, y and the registered copies
//   CNT_W   - width of the activity counter
//
// Ports:
//   clk      in   1      system clock, rising-edge active
//   rst      in   1      asynchronous active-high reset of all registered state
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   cnt_clr  in   1      synchronous clear of act_cnt (wins over increment)
//   y        out  WIDTH  combinational a | b
//   y_q      out  WIDTH  a | b registered on clk
//   rise     out  WIDTH  one-cycle pulse per bit on a 0->1 transition of y_q
//   any_q    out  1      reduction OR of y_q (registered alongside y_q)
//   act_cnt  out  CNT_W  cycles on which any_q was 1, saturating at all-ones
// ----------------------------------------------------------------------------
module or_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] rise,
  output logic             any_q,
  output logic [CNT_W-1:0] act_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Registered state and its next-state values
  logic [WIDTH-1:0] cap_q,  cap_d;   // registered copy of a | b
  logic [WIDTH-1:0] prev_q, prev_d;  // cap_q delayed one more cycle
  logic [WIDTH-1:0] rise_q, rise_d;  // edge pulses
  logic             act_q,  act_d;   // reduction OR aligned with cap_q
  logic [CNT_W-1:0] cnt_q,  cnt_d;   // activity counter

  // Combinational path: zero latency, independent of clock and reset.
  assign y = a | b;

  // Next-state logic for the capture stage. any is computed from the same
  // a | b value being captured so that any_q lines up with y_q.
  always_comb begin
    cap_d  = a | b;
    act_d  = |(a | b);
    prev_d = cap_q;
  end

  // Rising-edge detect per bit: compares the current registered copy against
  // the one before it, so a pulse lands one cycle after y_q goes high.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
      always_comb begin
        rise_d[gi] = cap_q[gi] & ~prev_q[gi];
      end
    end
  endgenerate

  // Activity counter: clear first, then a saturating increment driven by the
  // registered any flag (the counter trails any_q by one cycle).
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (act_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q  <= '0;
      prev_q <= '0;
      rise_q <= '0;
      act_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cap_q  <= cap_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y_q     = cap_q;
  assign rise    = rise_q;
  assign any_q   = act_q;
  assign act_cnt = cnt_q;

endmodule

// File: tb/tb_or_gate.sv
// ----------------------------------------------------------------------------
// tb_or_gate
//
// Directed bench for or_gate. Three instances share clk/rst:
//   u1 - WIDTH=1, CNT_W=16 (truth table, latency, counter, async reset)
//   u4 - WIDTH=4, CNT_W=16 (bitwise behaviour)
//   u3 - WIDTH=1, CNT_W=3  (counter saturation)
// Expected values are pushed to a scoreboard queue when stimulus is driven
// and popped when the corresponding DUT output is sampled.
// ----------------------------------------------------------------------------
module tb_or_gate;

  logic clk;
  logic clk_en;
  logic rst;

  // u1 signals
  logic        a1, b1, clr1;
  logic        y1, yq1, rise1, any1;
  logic [15:0] cnt1;

  // u4 signals
  logic [3:0]  a4, b4;
  logic        clr4;
  logic [3:0]  y4, yq4, rise4;
  logic        any4;
  logic [15:0] cnt4;

  // u3 signals
  logic        a3, b3, clr3;
  logic        y3, yq3, rise3, any3;
  logic [2:0]  cnt3;

  or_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cnt_clr(clr1),
    .y(y1), .y_q(yq1), .rise(rise1), .any_q(any1), .act_cnt(cnt1)
  );

  or_gate #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cnt_clr(clr4),
    .y(y4), .y_q(yq4), .rise(rise4), .any_q(any4), .act_cnt(cnt4)
  );

  or_gate #(.WIDTH(1), .CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .cnt_clr(clr3),
    .y(y3), .y_q(yq3), .rise(rise3), .any_q(any3), .act_cnt(cnt3)
  );

  // Clock only toggles once enabled, so the truth table runs with no clock.
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the sampled output.
  task automatic sb_check(input logic [31:0] obs);
    sb_entry_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h required=an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
        $display("[TB] %s observed=%h ok", e.tag, obs);
      else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock: wait for the rising edge, then sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net in case the clock never advances.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] tt_vec [4];
    logic       tt_exp [4];

    clk_en = 1'b0;
    rst    = 1'b1;
    a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
    a4 = 4'b0; b4 = 4'b0; clr4 = 1'b0;
    a3 = 1'b0; b3 = 1'b0; clr3 = 1'b0;
    #1;

    // Reset state with no clock running
    sb_push("rst_yq", 32'd0);    sb_check(32'(yq1));
    sb_push("rst_rise", 32'd0);  sb_check(32'(rise1));
    sb_push("rst_any", 32'd0);   sb_check(32'(any1));
    sb_push("rst_cnt", 32'd0);   sb_check(32'(cnt1));

    // Exhaustive truth table, clock stopped
    tt_vec[0] = 2'b00; tt_exp[0] = 1'b0;
    tt_vec[1] = 2'b01; tt_exp[1] = 1'b1;
    tt_vec[2] = 2'b10; tt_exp[2] = 1'b1;
    tt_vec[3] = 2'b11; tt_exp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = tt_vec[i][1];
      b1 = tt_vec[i][0];
      sb_push($sformatf("tt_%0d%0d", a1, b1), 32'(tt_exp[i]));
      #1;
      sb_check(32'(y1));
    end

    // Start clock and release reset between edges
    a1 = 1'b0; b1 = 1'b0;
    clk_en = 1'b1;
    #2;
    rst = 1'b0;
    tick();

    // Registered latency: a=1 before edge N
    a1 = 1'b1;
    sb_push("lat_yq_N", 32'd1);
    sb_push("lat_any_N", 32'd1);
    sb_push("lat_rise_N", 32'd0);
    tick();
    sb_check(32'(yq1));
    sb_check(32'(any1));
    sb_check(32'(rise1));
    sb_push("lat_rise_N1", 32'd1);
    tick();
    sb_check(32'(rise1));
    sb_push("lat_rise_N2", 32'd0);
    sb_push("lat_yq_N2", 32'd1);
    tick();
    sb_check(32'(rise1));
    sb_check(32'(yq1));

    // Counter: fresh reset, then a=1 for 5 cycles, then idle
    a1 = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    a1 = 1'b1;
    repeat (3) tick();
    sb_push("cnt_e3", 32'd2);
    sb_check(32'(cnt1));
    repeat (2) tick();
    a1 = 1'b0;
    sb_push("cnt_e6", 32'd5);
    tick();
    sb_check(32'(cnt1));
    sb_push("cnt_hold", 32'd5);
    repeat (2) tick();
    sb_check(32'(cnt1));

    // Clear while any_q is high: clear must win over the increment
    a1 = 1'b1;
    tick();
    clr1 = 1'b1;
    sb_push("cnt_clr", 32'd0);
    tick();
    sb_check(32'(cnt1));
    clr1 = 1'b0;
    sb_push("cnt_after_clr", 32'd1);
    tick();
    sb_check(32'(cnt1));
    tick();

    // Async reset mid-run, asserted between edges
    #2;
    rst = 1'b1;
    sb_push("arst_yq", 32'd0);
    sb_push("arst_rise", 32'd0);
    sb_push("arst_any", 32'd0);
    sb_push("arst_cnt", 32'd0);
    sb_push("arst_y", 32'd1);
    #1;
    sb_check(32'(yq1));
    sb_check(32'(rise1));
    sb_check(32'(any1));
    sb_check(32'(cnt1));
    sb_check(32'(y1));
    rst = 1'b0;
    a1 = 1'b0;

    // Bitwise behaviour, WIDTH=4
    tick();
    a4 = 4'b1010; b4 = 4'b0110;
    sb_push("w4_y", 32'h0000_000E);
    #1;
    sb_check(32'(y4));
    sb_push("w4_yq", 32'h0000_000E);
    sb_push("w4_any", 32'd1);
    tick();
    sb_check(32'(yq4));
    sb_check(32'(any4));
    sb_push("w4_rise", 32'h0000_000E);
    tick();
    sb_check(32'(rise4));
    a4 = 4'b0000; b4 = 4'b0000;
    sb_push("w4_y_zero", 32'd0);
    #1;
    sb_check(32'(y4));
    sb_push("w4_any_zero", 32'd0);
    sb_push("w4_yq_zero", 32'd0);
    tick();
    sb_check(32'(any4));
    sb_check(32'(yq4));
    a4 = 4'b0001;
    tick();
    sb_push("w4_rise_b0", 32'h0000_0001);
    tick();
    sb_check(32'(rise4));
    a4 = 4'b0000;

    // Saturation, CNT_W=3
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    a3 = 1'b1;
    repeat (7) tick();
    sb_push("sat_e7", 32'd6);
    sb_check(32'(cnt3));
    tick();
    sb_push("sat_e8", 32'd7);
    sb_check(32'(cnt3));
    repeat (2) tick();
    sb_push("sat_e10", 32'd7);
    sb_check(32'(cnt3));
    repeat (3) tick();
    sb_push("sat_nowrap", 32'd7);
    sb_check(32'(cnt3));
    a3 = 1'b0;

    // Every pushed expectation must have been consumed
    n_tests++;
    assert (sb_q.size() == 0)
      $display("[TB] sb_drained ok");
    else begin
      n_fail++;
      $error("FAIL sb_drained observed=%0d required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
